// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite draw scheduler.
// Holds frame geometry, field widths, the FSM state type and the table entry layout.
package sprite_pkg;

   localparam int FRAME_W  = 640;
   localparam int FRAME_H  = 480;
   localparam int MAX_ADDR = FRAME_W * FRAME_H;
   localparam int COORD_W  = 19;
   localparam int IMG_W    = 8;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      ISSUE,
      WAIT,
      FIN
   } state_e;

   typedef struct packed {
      logic               valid;
      logic [COORD_W-1:0] coord;
      logic [IMG_W-1:0]   img;
   } sprite_entry_t;

endpackage

// File: rtl/sprite_table.sv
// Sprite entry register file: one synchronous write port, one combinational read port.
// A write is visible to the read port from the cycle after its clock edge.
module sprite_table
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES = 16,
   parameter int IDX_W       = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               we,
   input  logic [IDX_W-1:0]   wr_idx,
   input  logic               wr_valid,
   input  logic [COORD_W-1:0] wr_coord,
   input  logic [IMG_W-1:0]   wr_img,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic               rd_valid,
   output logic [COORD_W-1:0] rd_coord,
   output logic [IMG_W-1:0]   rd_img
);

   sprite_entry_t mem [NUM_SPRITES];

   // NOTE: the table is small and must come up empty, so every entry is reset;
   // a large RAM would instead rely on the valid bits alone being cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[wr_idx] <= {wr_valid, wr_coord, wr_img};
      end
   end

   assign rd_valid = mem[rd_idx].valid;
   assign rd_coord = mem[rd_idx].coord;
   assign rd_img   = mem[rd_idx].img;

endmodule

// File: rtl/sprite_draw_sched.sv
// Per-frame scheduler: walks the sprite table on frame_start and issues one
// start/done transaction to draw_sprite per valid, in-range entry.
module sprite_draw_sched
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES = 16,
   parameter int IDX_W       = 4,
   parameter int MAX_ADDR    = sprite_pkg::MAX_ADDR,
   parameter int TIMEOUT     = 8192
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tbl_we,
   input  logic [IDX_W-1:0]   tbl_idx,
   input  logic               tbl_valid,
   input  logic [COORD_W-1:0] tbl_coord,
   input  logic [IMG_W-1:0]   tbl_img,
   input  logic               frame_start,
   input  logic               draw_done,
   input  logic               clr_err,
   output logic               draw_start,
   output logic [COORD_W-1:0] draw_coord,
   output logic [IMG_W-1:0]   draw_img,
   output logic               busy,
   output logic               frame_done,
   output logic [IDX_W:0]     drawn_cnt,
   output logic               timeout_err,
   output logic               overrun_err
);

   localparam int                 CNT_W      = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_SPRITES - 1);
   localparam logic [COORD_W-1:0] ADDR_LIMIT = COORD_W'(MAX_ADDR);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W:0]     drawn_q, drawn_d;
   logic [COORD_W-1:0] coord_q, coord_d;
   logic [IMG_W-1:0]   img_q, img_d;
   logic               timeout_q, overrun_q;
   logic               timeout_evt, overrun_evt;

   logic               rd_valid;
   logic [COORD_W-1:0] rd_coord;
   logic [IMG_W-1:0]   rd_img;

   sprite_table #(
      .NUM_SPRITES(NUM_SPRITES),
      .IDX_W      (IDX_W)
   ) u_table (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (tbl_we),
      .wr_idx  (tbl_idx),
      .wr_valid(tbl_valid),
      .wr_coord(tbl_coord),
      .wr_img  (tbl_img),
      .rd_idx  (idx_q),
      .rd_valid(rd_valid),
      .rd_coord(rd_coord),
      .rd_img  (rd_img)
   );

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      drawn_d     = drawn_q;
      coord_d     = coord_q;
      img_d       = img_q;
      timeout_evt = 1'b0;
      overrun_evt = frame_start && (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = SCAN;
               idx_d   = '0;
               drawn_d = '0;
            end
         end
         SCAN: begin
            if (rd_valid && (rd_coord < ADDR_LIMIT)) begin
               coord_d = rd_coord;
               img_d   = rd_img;
               state_d = ISSUE;
            end else if (idx_q == IDX_LAST) begin
               state_d = FIN;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ISSUE: begin
            drawn_d = drawn_q + 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A done arriving on the timeout cycle still counts as a clean finish.
            if (draw_done || (cnt_q == CNT_LAST)) begin
               timeout_evt = !draw_done;
               if (idx_q == IDX_LAST) begin
                  state_d = FIN;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = SCAN;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         drawn_q   <= '0;
         coord_q   <= '0;
         img_q     <= '0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         drawn_q   <= drawn_d;
         coord_q   <= coord_d;
         img_q     <= img_d;
         timeout_q <= timeout_evt | (timeout_q & ~clr_err);
         overrun_q <= overrun_evt | (overrun_q & ~clr_err);
      end
   end

   assign draw_start  = (state_q == ISSUE);
   assign busy        = (state_q == SCAN) || (state_q == ISSUE) || (state_q == WAIT);
   assign frame_done  = (state_q == FIN);
   assign draw_coord  = coord_q;
   assign draw_img    = img_q;
   assign drawn_cnt   = drawn_q;
   assign timeout_err = timeout_q;
   assign overrun_err = overrun_q;

endmodule

// File: tb/tb_sprite_draw_sched.sv
// Self-checking bench for sprite_draw_sched: directed and randomized sweeps
// compared against a table-level model of which sprites get drawn and when.
module tb_sprite_draw_sched;

   localparam int N       = 16;
   localparam int IW      = 4;
   localparam int TMO     = 16;
   localparam int LIMIT   = 640 * 480;
   localparam int BUDGET  = 2000;

   logic          clk;
   logic          rst_n;
   logic          tbl_we;
   logic [IW-1:0] tbl_idx;
   logic          tbl_valid;
   logic [18:0]   tbl_coord;
   logic [7:0]    tbl_img;
   logic          frame_start;
   logic          draw_done;
   logic          clr_err;
   logic          draw_start;
   logic [18:0]   draw_coord;
   logic [7:0]    draw_img;
   logic          busy;
   logic          frame_done;
   logic [IW:0]   drawn_cnt;
   logic          timeout_err;
   logic          overrun_err;

   sprite_draw_sched #(
      .NUM_SPRITES(N),
      .IDX_W      (IW),
      .MAX_ADDR   (LIMIT),
      .TIMEOUT    (TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tbl_we     (tbl_we),
      .tbl_idx    (tbl_idx),
      .tbl_valid  (tbl_valid),
      .tbl_coord  (tbl_coord),
      .tbl_img    (tbl_img),
      .frame_start(frame_start),
      .draw_done  (draw_done),
      .clr_err    (clr_err),
      .draw_start (draw_start),
      .draw_coord (draw_coord),
      .draw_img   (draw_img),
      .busy       (busy),
      .frame_done (frame_done),
      .drawn_cnt  (drawn_cnt),
      .timeout_err(timeout_err),
      .overrun_err(overrun_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int coord;
      int img;
   } draw_t;

   // Host-side view of the table
   bit m_valid [N];
   int m_coord [N];
   int m_img   [N];

   int    n_pass  = 0;
   int    n_total = 0;
   draw_t got [$];
   int    first_start_cyc;
   int    te_cyc;
   int    done_cyc;
   int    mid_fs_cyc  = -1;
   int    mid_wr_cyc  = -1;
   int    mid_wr_idx, mid_wr_coord, mid_wr_img;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic write_entry(input int idx, input bit v, input int c, input int im);
      tbl_we    = 1'b1;
      tbl_idx   = IW'(idx);
      tbl_valid = v;
      tbl_coord = 19'(c);
      tbl_img   = 8'(im);
      @(negedge clk);
      tbl_we = 1'b0;
      m_valid[idx] = v;
      m_coord[idx] = c;
      m_img[idx]   = im;
   endtask

   task automatic clear_table();
      for (int i = 0; i < N; i++) write_entry(i, 1'b0, 0, 0);
   endtask

   // d > 0: draw_done returned d cycles after each draw_start; d == 0: never returned.
   task automatic run_sweep(input int d, input string tag);
      draw_t       exp_q [$];
      bit          in_txn = 1'b0;
      bit          unstable = 1'b0;
      logic [18:0] hc = '0;
      logic [7:0]  hi = '0;
      int          cd = 0;
      int          wait_len;
      got.delete();
      first_start_cyc = -1;
      te_cyc          = -1;
      done_cyc        = -1;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check({tag, "/busy_start"}, busy, 1);
      for (int cyc = 1; cyc < BUDGET && done_cyc < 0; cyc++) begin
         if (timeout_err && te_cyc < 0) te_cyc = cyc;
         if (in_txn && (draw_coord !== hc || draw_img !== hi)) unstable = 1'b1;
         if (frame_done) begin
            done_cyc = cyc;
            in_txn   = 1'b0;
            check({tag, "/busy_at_done"}, busy, 0);
         end
         draw_done   = 1'b0;
         frame_start = 1'b0;
         tbl_we      = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               draw_done = 1'b1;
               in_txn    = 1'b0;
            end
         end
         if (draw_start) begin
            got.push_back('{int'(draw_coord), int'(draw_img)});
            hc     = draw_coord;
            hi     = draw_img;
            in_txn = 1'b1;
            cd     = d;
            if (first_start_cyc < 0) first_start_cyc = cyc;
         end
         if (cyc == mid_fs_cyc) frame_start = 1'b1;
         if (cyc == mid_wr_cyc) begin
            tbl_we    = 1'b1;
            tbl_idx   = IW'(mid_wr_idx);
            tbl_valid = 1'b1;
            tbl_coord = 19'(mid_wr_coord);
            tbl_img   = 8'(mid_wr_img);
            m_valid[mid_wr_idx] = 1'b1;
            m_coord[mid_wr_idx] = mid_wr_coord;
            m_img[mid_wr_idx]   = mid_wr_img;
         end
         @(negedge clk);
      end
      tbl_we = 1'b0; draw_done = 1'b0; frame_start = 1'b0;
      mid_fs_cyc = -1;
      mid_wr_cyc = -1;

      for (int i = 0; i < N; i++)
         if (m_valid[i] && m_coord[i] < LIMIT) exp_q.push_back('{m_coord[i], m_img[i]});
      wait_len = (d > 0) ? d : TMO;
      check({tag, "/done_seen"}, (done_cyc >= 0), 1);
      check({tag, "/latency"}, done_cyc, N + exp_q.size() * (1 + wait_len) + 1);
      check({tag, "/done_pulse"}, frame_done, 0);
      check({tag, "/busy_after"}, busy, 0);
      check({tag, "/drawn_cnt"}, drawn_cnt, exp_q.size());
      check({tag, "/n_draws"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         check($sformatf("%s/coord%0d", tag, i), got[i].coord, exp_q[i].coord);
         check($sformatf("%s/img%0d", tag, i), got[i].img, exp_q[i].img);
      end
      check({tag, "/stable"}, unstable, 0);
   endtask

   initial begin
      rst_n = 1'b0; tbl_we = 1'b0; tbl_idx = '0; tbl_valid = 1'b0; tbl_coord = '0;
      tbl_img = '0; frame_start = 1'b0; draw_done = 1'b0; clr_err = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0; m_coord[i] = 0; m_img[i] = 0;
      end
      repeat (2) @(negedge clk);
      check("reset/draw_start", draw_start, 0);
      check("reset/busy", busy, 0);
      check("reset/frame_done", frame_done, 0);
      check("reset/drawn_cnt", drawn_cnt, 0);
      check("reset/coord", draw_coord, 0);
      check("reset/errs", {timeout_err, overrun_err}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Empty table
      run_sweep(4, "empty");

      // Three valid entries including both coordinate extremes
      write_entry(0, 1'b1, 0, 0);
      write_entry(5, 1'b1, 1000, 3);
      write_entry(15, 1'b1, LIMIT - 1, 255);
      run_sweep(4, "three");
      check("three/errs", {timeout_err, overrun_err}, 0);

      // Out-of-range coordinate is skipped
      clear_table();
      write_entry(2, 1'b1, LIMIT, 9);
      write_entry(3, 1'b1, 4242, 17);
      run_sweep(2, "range");

      // Draw never completes
      clear_table();
      write_entry(0, 1'b1, 777, 5);
      run_sweep(0, "tmo");
      check("tmo/err_delay", te_cyc - first_start_cyc, 17);
      check("tmo/err_set", timeout_err, 1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("tmo/cleared", timeout_err, 0);

      // Overrun during WAIT plus a write ahead of the scan pointer
      clear_table();
      write_entry(1, 1'b1, $urandom_range(0, LIMIT - 1), $urandom_range(0, 255));
      mid_fs_cyc   = 5;
      mid_wr_cyc   = 5;
      mid_wr_idx   = 12;
      mid_wr_coord = $urandom_range(0, LIMIT - 1);
      mid_wr_img   = $urandom_range(0, 255);
      run_sweep(4, "overrun");
      check("overrun/flag", overrun_err, 1);
      check("overrun/no_tmo", timeout_err, 0);

      // Randomized tables and draw latencies
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < N; i++) begin
            int c;
            case ($urandom_range(0, 3))
               0:       c = LIMIT - 1;
               1:       c = LIMIT;
               2:       c = $urandom_range(LIMIT, 524287);
               default: c = $urandom_range(0, LIMIT - 1);
            endcase
            write_entry(i, ($urandom_range(0, 2) == 0), c, $urandom_range(0, 255));
         end
         run_sweep($urandom_range(1, 5), $sformatf("rand%0d", s));
      end

      // Asynchronous reset in the middle of a transaction
      clear_table();
      write_entry(1, 1'b1, 1234, 7);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst/busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("midrst/draw_start", draw_start, 0);
      check("midrst/busy", busy, 0);
      check("midrst/frame_done", frame_done, 0);
      check("midrst/drawn_cnt", drawn_cnt, 0);
      check("midrst/coord", draw_coord, 0);
      check("midrst/img", draw_img, 0);
      check("midrst/errs", {timeout_err, overrun_err}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0; m_coord[i] = 0; m_img[i] = 0;
      end
      @(negedge clk);
      run_sweep(3, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
